// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, ALU and display signals of the calculator sequencer.
// master: the sequencer (consumes keys and ALU results, drives ALU launch and display).
// slave : the environment (keypad decoder, ALU datapath, display path).
interface calc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             key_valid;
    logic             key_is_digit;
    logic [3:0]       key_code;
    logic             alu_start;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] display_value;
    logic             result_valid;
    logic             error;
    logic             busy;
    modport master (
        input  key_valid, key_is_digit, key_code, alu_done, alu_result, alu_err,
        output alu_start, alu_a, alu_b, alu_op, display_value, result_valid, error, busy
    );
    modport slave (
        output key_valid, key_is_digit, key_code, alu_done, alu_result, alu_err,
        input  alu_start, alu_a, alu_b, alu_op, display_value, result_valid, error, busy
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operation sequencer for the calculator.
// Ports: clk, rst (sync, active-high), bus_io (calc_sequencer_if.master: keys in,
// ALU start/done handshake, display value, result pulse, error and busy levels).
module calc_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    calc_sequencer_if.master  bus_io
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, WAIT, SHOW, ERR} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] acc_a_q, acc_b_q, alu_a_q, alu_b_q, disp_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q, next_op_q, alu_op_q;
    logic             chain_q, alu_start_q, rv_q, err_q, busy_q;
    logic             is_dig, dig_ok, is_op, is_eq, is_clr;
    logic [WIDTH-1:0] acc_a_d, acc_b_d;
    assign is_dig  = bus_io.key_valid && bus_io.key_is_digit && bus_io.key_code <= 4'd9;
    assign dig_ok  = is_dig && cnt_q < CW'(MAX_DIGITS);
    assign is_op   = bus_io.key_valid && !bus_io.key_is_digit && bus_io.key_code < 4'd4;
    assign is_eq   = bus_io.key_valid && !bus_io.key_is_digit && bus_io.key_code == 4'd4;
    assign is_clr  = bus_io.key_valid && !bus_io.key_is_digit && bus_io.key_code == 4'd5;
    assign acc_a_d = acc_a_q * WIDTH'(10) + WIDTH'(bus_io.key_code);
    assign acc_b_d = acc_b_q * WIDTH'(10) + WIDTH'(bus_io.key_code);
    // CLR shares the reset path so it also wins over a coincident alu_done.
    always_ff @(posedge clk) begin
        if (rst || is_clr) begin
            state_q     <= ENTER_A;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            next_op_q   <= '0;
            chain_q     <= 1'b0;
            alu_start_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            disp_q      <= '0;
            rv_q        <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            alu_start_q <= 1'b0;
            rv_q        <= 1'b0;
            case (state_q)
                ENTER_A: begin
                    if (dig_ok) begin
                        acc_a_q <= acc_a_d;
                        cnt_q   <= cnt_q + 1'b1;
                        disp_q  <= acc_a_d;
                    end else if (is_op) begin
                        op_q    <= bus_io.key_code[1:0];
                        acc_b_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (dig_ok) begin
                        acc_b_q <= acc_b_d;
                        cnt_q   <= cnt_q + 1'b1;
                        disp_q  <= acc_b_d;
                    end else if (is_op && cnt_q == '0) begin
                        op_q <= bus_io.key_code[1:0];
                    end else if ((is_op || is_eq) && cnt_q != '0) begin
                        // An operator here both launches the pending op and queues the next one.
                        chain_q     <= is_op;
                        next_op_q   <= bus_io.key_code[1:0];
                        alu_start_q <= 1'b1;
                        alu_a_q     <= acc_a_q;
                        alu_b_q     <= acc_b_q;
                        alu_op_q    <= op_q;
                        busy_q      <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: state_q <= WAIT;
                WAIT: begin
                    if (bus_io.alu_done) begin
                        busy_q <= 1'b0;
                        if (bus_io.alu_err) begin
                            err_q   <= 1'b1;
                            disp_q  <= '0;
                            state_q <= ERR;
                        end else begin
                            acc_a_q <= bus_io.alu_result;
                            disp_q  <= bus_io.alu_result;
                            rv_q    <= 1'b1;
                            if (chain_q) begin
                                op_q    <= next_op_q;
                                acc_b_q <= '0;
                                cnt_q   <= '0;
                                state_q <= ENTER_B;
                            end else begin
                                state_q <= SHOW;
                            end
                        end
                    end
                end
                SHOW: begin
                    if (is_dig) begin
                        acc_a_q <= WIDTH'(bus_io.key_code);
                        cnt_q   <= CW'(1);
                        disp_q  <= WIDTH'(bus_io.key_code);
                        state_q <= ENTER_A;
                    end else if (is_op) begin
                        op_q    <= bus_io.key_code[1:0];
                        acc_b_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ENTER_B;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus_io.alu_start     = alu_start_q;
    assign bus_io.alu_a         = alu_a_q;
    assign bus_io.alu_b         = alu_b_q;
    assign bus_io.alu_op        = alu_op_q;
    assign bus_io.display_value = disp_q;
    assign bus_io.result_valid  = rv_q;
    assign bus_io.error         = err_q;
    assign bus_io.busy          = busy_q;
endmodule
